// File: rtl/config_loader.sv
// Serial configuration loader: streams host words LSB-first into a programming chain.
// Define CFG_READBACK_EN to add capture of the old chain contents on rb_data/rb_valid.
module config_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              chain_out,
  output logic              chain_en,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
`ifdef CFG_READBACK_EN
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: a word moves on a rising edge where in_valid && in_ready are both
  // high; in_ready is high only in FETCH, and in_valid may drop at any time.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int              WB_W = $clog2(DATA_W + 1);
  localparam logic [15:0]     LEN  = 16'(CHAIN_LEN);
  localparam logic [WB_W-1:0] DW   = WB_W'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [15:0]       bit_cnt;
  logic [WB_W-1:0]   wbit;

  assign state_dbg = state;

  // bit_cnt and wbit count the bit currently on chain_out, so the exit test
  // in SHIFT happens while the last bit of a word or of the chain is on the wire.
  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      wbit      <= '0;
      in_ready  <= 1'b0;
      chain_out <= 1'b0;
      chain_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bit_cnt  <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (in_valid) begin
            shift_reg <= in_data >> 1;
            chain_out <= in_data[0];
            chain_en  <= 1'b1;
            bit_cnt   <= bit_cnt + 16'd1;
            wbit      <= WB_W'(1);
            in_ready  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == LEN) begin
            chain_en  <= 1'b0;
            chain_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (wbit == DW) begin
            chain_en  <= 1'b0;
            chain_out <= 1'b0;
            in_ready  <= 1'b1;
            state     <= FETCH;
          end else begin
            chain_out <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 16'd1;
            wbit      <= wbit + WB_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CFG_READBACK_EN
  logic [DATA_W-1:0] rb_shift;
  logic [DATA_W-1:0] rb_next;

  // Tail bits enter at the MSB so the first bit read back ends up in bit 0;
  // a short final word is shifted down to stay LSB-aligned with zero fill.
  assign rb_next = {chain_tail, rb_shift[DATA_W-1:1]};

  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      rb_shift <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (chain_en) begin
        if (wbit == DW || bit_cnt == LEN) begin
          rb_data  <= rb_next >> (DW - wbit);
          rb_valid <= 1'b1;
          rb_shift <= '0;
        end else begin
          rb_shift <= rb_next;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = chain_tail;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: scoreboard on the serial stream, chain model for readback,
// directed loads, randomized loads, reset abort, and a short-chain instance.
module tb_config_loader;

  localparam int L  = 12;
  localparam int W  = 8;
  localparam int L8 = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, chain_out, chain_en, chain_tail, busy, done;
  logic [1:0]   state_dbg;
`ifdef CFG_READBACK_EN
  logic [W-1:0] rb_data;
  logic         rb_valid;
`endif

  logic         start8 = 1'b0;
  logic [W-1:0] in_data8 = '0;
  logic         in_valid8 = 1'b0;
  logic         chain_tail8 = 1'b0;
  logic         in_ready8, chain_out8, chain_en8, busy8, done8;
  logic [1:0]   state_dbg8;
`ifdef CFG_READBACK_EN
  logic [W-1:0] rb_data8;
  logic         rb_valid8;
`endif

  config_loader #(.CHAIN_LEN(L), .DATA_W(W)) u_dut (
    .prog_clk(clk), .prog_rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .chain_out(chain_out),
    .chain_en(chain_en), .chain_tail(chain_tail), .busy(busy), .done(done),
`ifdef CFG_READBACK_EN
    .rb_data(rb_data), .rb_valid(rb_valid),
`endif
    .state_dbg(state_dbg)
  );

  config_loader #(.CHAIN_LEN(L8), .DATA_W(W)) u_dut8 (
    .prog_clk(clk), .prog_rst(rst), .start(start8), .in_data(in_data8),
    .in_valid(in_valid8), .in_ready(in_ready8), .chain_out(chain_out8),
    .chain_en(chain_en8), .chain_tail(chain_tail8), .busy(busy8), .done(done8),
`ifdef CFG_READBACK_EN
    .rb_data(rb_data8), .rb_valid(rb_valid8),
`endif
    .state_dbg(state_dbg8)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // chain model: L-bit shift chain fed by chain_out, tail is its last element
  logic [L-1:0] chain = '0;
  logic [L-1:0] preload_val = '0;
  logic         preload_req = 1'b0;
  assign chain_tail = chain[L-1];

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (chain_en) chain <= {chain[L-2:0], chain_out};
  end

  // scoreboard
  logic [0:0]   exp_q[$];
  logic [W-1:0] rb_exp_q[$];
  logic [W-1:0] words[$];
  int           en_cnt = 0;
  logic [L-1:0] obs_bits = '0;

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_en_excl", {31'd0, in_ready & chain_en}, 32'd0);
      check("ready_needs_busy", {31'd0, in_ready & ~busy}, 32'd0);
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (chain_en) begin
        if (exp_q.size() == 0) check("extra_bit", 32'd1, 32'd0);
        else check("chain_out", {31'd0, chain_out}, {31'd0, exp_q.pop_front()});
        if (en_cnt < L) obs_bits[en_cnt] = chain_out;
        en_cnt++;
      end
    end
  end

`ifdef CFG_READBACK_EN
  always @(negedge clk) begin
    if (!rst && rb_valid) begin
      if (rb_exp_q.size() == 0) check("rb_extra", 32'd1, 32'd0);
      else check("rb_data", {24'd0, rb_data}, {24'd0, rb_exp_q.pop_front()});
    end
  end
`endif

  // driver tasks
  task automatic preload(input logic [L-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic set_expect();
    exp_q.delete();
    en_cnt = 0;
    obs_bits = '0;
    for (int i = 0; i < words.size(); i++)
      for (int b = 0; b < W; b++)
        if (i * W + b < L) exp_q.push_back(words[i][b]);
`ifdef CFG_READBACK_EN
    begin
      logic [W-1:0] acc;
      int k;
      rb_exp_q.delete();
      acc = '0;
      k = 0;
      for (int j = L - 1; j >= 0; j--) begin
        acc[k] = chain[j];
        k++;
        if (k == W || j == 0) begin
          rb_exp_q.push_back(acc);
          acc = '0;
          k = 0;
        end
      end
    end
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic accept_word(output bit ok);
    bit r;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One load of words[]; gap = idle edges before the next word is offered,
  // poke = pulse start while the first word is shifting.
  task automatic do_load(input int gap, input bit poke);
    int n, t0, extra, waited;
    bit ok;
    n = words.size();
    set_expect();
    extra = 0;
    pulse_start();
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      in_data = words[i];
      in_valid = 1'b1;
      accept_word(ok);
      check("accept", {31'd0, ok}, 32'd1);
      in_valid = 1'b0;
      if (i < n - 1) begin
        waited = 0;
        if (poke && i == 0) begin
          repeat (3) begin @(posedge clk); #1; end
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          waited = 4;
        end
        repeat (gap) begin @(posedge clk); #1; end
        waited += gap;
        if (waited > W) extra += waited - W;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, ok}, 32'd1);
    check("load_latency", cyc - t0, n + L + extra);
    @(negedge clk);
    check("en_count", en_cnt, L);
    check("exp_left", exp_q.size(), 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("ready_after", {31'd0, in_ready}, 32'd0);
    check("done_held", {31'd0, done}, 32'd1);
`ifdef CFG_READBACK_EN
    check("rb_left", rb_exp_q.size(), 32'd0);
`endif
  endtask

  initial begin
    bit ok;
    logic [7:0] bits8;
    int en8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_en", {31'd0, chain_en}, 32'd0);
    check("rst_out", {31'd0, chain_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
`ifdef CFG_READBACK_EN
    check("rst_rb_valid", {31'd0, rb_valid}, 32'd0);
    check("rst_rb_data", {24'd0, rb_data}, 32'd0);
`endif
    rst = 1'b0;

    // back-to-back 0xA5, 0x3C into an all-ones chain
    preload('1);
    words.delete();
    words.push_back(8'hA5);
    words.push_back(8'h3C);
    do_load(0, 1'b0);
    check("stream_a5_3c", {20'd0, obs_bits}, 32'hCA5);

    // five stalled FETCH cycles between the words
    do_load(W + 5, 1'b0);
    check("stream_stalled", {20'd0, obs_bits}, 32'hCA5);

    // start during SHIFT must not disturb the load
    words.delete();
    words.push_back(8'($urandom_range(0, 255)));
    words.push_back(8'($urandom_range(0, 255)));
    do_load(0, 1'b1);

    // reset after six shifted bits abandons the load
    words.delete();
    words.push_back(8'($urandom_range(0, 255)));
    words.push_back(8'($urandom_range(0, 255)));
    set_expect();
    pulse_start();
    in_data = words[0];
    in_valid = 1'b1;
    accept_word(ok);
    check("rst_accept", {31'd0, ok}, 32'd1);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (en_cnt >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_wait", {31'd0, ok}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_en", {31'd0, chain_en}, 32'd0);
    check("abort_out", {31'd0, chain_out}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    rb_exp_q.delete();
    do_load(0, 1'b0);

    // randomized loads
    for (int r = 0; r < 8; r++) begin
      preload(L'($urandom));
      words.delete();
      words.push_back(8'($urandom_range(0, 255)));
      words.push_back(8'($urandom_range(0, 255)));
      do_load($urandom_range(0, 14), 1'($urandom_range(0, 1)));
    end

    // short chain: one word 0x81 fills it exactly
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    in_data8 = 8'h81;
    in_valid8 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ok = in_ready8;
      @(posedge clk); #1;
      if (ok) break;
    end
    check("accept8", {31'd0, ok}, 32'd1);
    in_valid8 = 1'b0;
    en8 = 0;
    bits8 = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("ready8_low", {31'd0, in_ready8}, 32'd0);
      if (chain_en8) begin
        if (en8 < 8) bits8[en8] = chain_out8;
        en8++;
      end
    end
    check("en8_count", en8, 32'd8);
    check("stream8", {24'd0, bits8}, 32'h81);
    check("done8", {31'd0, done8}, 32'd1);
    check("busy8", {31'd0, busy8}, 32'd0);
    check("state8", {30'd0, state_dbg8}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The module SHALL have parameter CHAIN_LEN, default 40, meaning the total number of configuration bits in the downstream programming chain (valid range 1..65535).
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning the width of each host data word.
REQ-003 The module SHALL have port prog_clk, input, 1 bit: the single clock, shared with the programming chain.
REQ-004 The module SHALL have port prog_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 The module SHALL have port in_data, input, DATA_W bits: host configuration word, shifted out LSB first.
REQ-007 The module SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the loader accepts in_data this cycle.
REQ-009 The module SHALL have port chain_out, output, 1 bit: serial bit driven onto prog_in of the first chain element.
REQ-010 The module SHALL have port chain_en, output, 1 bit: shift enable driven onto prog_en of the chain.
REQ-011 The module SHALL have port chain_tail, input, 1 bit: prog_out of the last chain element.
REQ-012 The module SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 The module SHALL have port done, output, 1 bit: the last load completed.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, SHIFT and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL clear the bit counter and done, and enter FETCH on the next edge.
REQ-016 start SHALL be ignored in FETCH and SHIFT.
REQ-017 In FETCH, in_ready SHALL be 1; in_valid=1 SHALL latch in_data into a shift register and enter SHIFT.
REQ-018 In FETCH, in_valid=0 SHALL hold the state with chain_en=0, so the chain is stalled and not corrupted.
REQ-019 In SHIFT, every cycle SHALL drive chain_en=1 and chain_out=shift_reg[0], then right-shift the register and increment the 16-bit bit counter.
REQ-020 SHIFT SHALL return to FETCH after DATA_W bits of the current word, or enter DONE when the counter reaches CHAIN_LEN, whichever comes first.
REQ-021 In the final word, bits beyond CHAIN_LEN SHALL be discarded and never shifted out.
REQ-022 chain_out and chain_en SHALL be registered outputs, and chain_en SHALL be high for exactly CHAIN_LEN cycles per load.
REQ-023 busy SHALL be 1 in FETCH and SHIFT and 0 otherwise.
REQ-024 done SHALL be 1 in DONE and held there until the next accepted start.
REQ-025 in_ready SHALL be 0 outside FETCH.
REQ-026 Latency SHALL be: start to first FETCH in 1 cycle; accepted word to its first chain_en in 1 cycle; sustained throughput DATA_W bits per DATA_W+1 cycles.

Reset
REQ-027 prog_rst=1 SHALL asynchronously force IDLE, with the counter at 0, the shift register at 0, and in_ready, chain_out, chain_en, busy and done all at 0.
REQ-028 A reset during a load SHALL abandon the load, and chain_en SHALL be 0 from reset assertion onward.

Configuration
REQ-029 With macro CFG_READBACK_EN defined, the module SHALL add outputs rb_data (DATA_W bits) and rb_valid (1 bit).
REQ-030 With CFG_READBACK_EN defined, on every chain_en cycle the module SHALL shift chain_tail MSB-first into a readback register, i.e. the old chain contents.
REQ-031 With CFG_READBACK_EN defined, rb_valid SHALL pulse for 1 cycle with rb_data when DATA_W bits have been collected or on the final bit; a partial last word SHALL be LSB-aligned and zero-padded.
REQ-032 With CFG_READBACK_EN defined, rb_data and rb_valid SHALL reset to 0.
REQ-033 Without CFG_READBACK_EN, the rb ports and readback logic SHALL be absent and chain_tail SHALL be unused.

Verification
REQ-034 CHAIN_LEN=12, DATA_W=8, words 0xA5, 0x3C sent back-to-back -> chain_out sequence 1,0,1,0,0,1,0,1,0,0,1,1; chain_en high 12 cycles; done=1 afterwards.
REQ-035 in_valid held low 5 cycles between words -> chain_en=0 for those cycles and the serial stream is identical to REQ-034.
REQ-036 start asserted during SHIFT -> ignored and the bit count is unchanged.
REQ-037 prog_rst pulsed after 6 shifted bits -> all outputs 0 immediately; a new start then produces a full 12-bit load.
REQ-038 CFG_READBACK_EN, chain model preloaded with 0xFFF -> rb_data 0xFF then 0x0F, one rb_valid pulse each.
REQ-039 CHAIN_LEN=8, one word 0x81 -> exactly 8 chain_en cycles, in_ready never re-asserted, DONE reached.
